rdma_filter: RTL and testbench
==============================

# rdma_filter

Ingress filter between the Ethernet MAC receive stream and `rdma_recv`. Inspects the first 64-byte beat of every incoming frame, forwards frames that are well-formed RDMA-over-UDP packets unchanged onto `AXIS_RDMA`, and silently discards all other frames. Keeps running counts of passed and dropped frames for status registers.

## Interface
- `DATA_WBITS`, 512, stream data width in bits; fixed at 512 because the header occupies exactly one beat.
- `DATA_WBYTS`, DATA_WBITS/8, TKEEP width.
- `RDMA_MAGIC`, 16'h0122, required value of the RDMA magic field.
- `RDMA_UDP_PORT`, 16'd32002, required UDP destination port; used only with the port check compiled in.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `AXIS_ETH_TDATA`  in  512  frame data; packet byte 0 is in [7:0].
- `AXIS_ETH_TKEEP`  in  64  byte enables.
- `AXIS_ETH_TLAST`  in  1  last beat of frame.
- `AXIS_ETH_TVALID`  in  1  beat valid.
- `AXIS_ETH_TREADY`  out  1  beat accepted.
- `AXIS_RDMA_TDATA`, `AXIS_RDMA_TKEEP`, `AXIS_RDMA_TLAST`, `AXIS_RDMA_TVALID`  out  512/64/1/1  filtered stream.
- `AXIS_RDMA_TREADY`  in  1  downstream ready.
- `packets_passed`  out  64  frames forwarded.
- `packets_dropped`  out  64  frames discarded.

## Operation
- Header fields are taken from beat 0. Multi-byte fields are big-endian, i.e. the lower byte offset is the MSB:
  - frame type: bytes 12–13
  - IP protocol: byte 23
  - UDP destination port: bytes 36–37
  - UDP length: bytes 38–39
  - RDMA magic: bytes 42–43
- A frame is accepted when all of the following hold:
  - frame type == 16'h0800
  - IP protocol == 8'd17
  - magic == `RDMA_MAGIC`
  - UDP length >= 31, i.e. 8 UDP header + 22 RDMA header + at least 1 data byte
  - beat 0 does not carry TLAST
  - port check passes, when it is compiled in
- State machine:
  - HDR: entered on reset. On a header beat handshake:
    - If accepted, forward the beat. Go to PASS, or stay in HDR if TLAST=1 (cannot happen for an accepted frame).
    - If rejected, do not forward the beat. Go to DROP, or stay in HDR when TLAST=1.
  - PASS: forward every beat. On a TLAST handshake, return to HDR and increment `packets_passed`. The counter increments when the last beat enters the output register.
  - DROP: consume beats without forwarding. On a TLAST handshake, return to HDR.
  - `packets_dropped` increments once per rejected frame, on its TLAST handshake. A single-beat rejected frame increments it on the header beat.
- Output path is a single register stage carrying TDATA, TKEEP, TLAST and TVALID. TDATA, TKEEP and TLAST pass unmodified.
- `AXIS_ETH_TREADY = !AXIS_RDMA_TVALID | AXIS_RDMA_TREADY`, in every state. Dropped beats are still gated by this term so the logic stays simple.
- Counters wrap modulo 2^64.

## Timing
- Latency: a beat accepted at edge N appears on `AXIS_RDMA` from cycle N+1.
- Full throughput of 1 beat/clk while downstream is ready.
- The output register holds its beat stable while TVALID=1 and TREADY=0.
- When the output register is full and downstream is stalled, TREADY drops low the same cycle (combinational) and no beat is lost.
- Simultaneous output drain and input accept in one cycle is a legal back-to-back transfer.
- Reset values:
  - `AXIS_RDMA_TVALID` = 0
  - `AXIS_ETH_TREADY` = 1 (follows from TVALID=0)
  - state = HDR
  - both counters = 0
  - output data/keep/last: don't-care
- Reset mid-frame discards any beat in the output register, which is never presented. The next input beat is treated as a header, and aligning the upstream MAC to a frame boundary is the system's responsibility.
- Reset has priority over any handshake in the same cycle.

## Configuration
- `RDMA_FILTER_PORT_CHECK_EN` defined: the UDP destination port must equal `RDMA_UDP_PORT` for a frame to be accepted.
- Macro undefined: the port is ignored, and the `RDMA_UDP_PORT` parameter is unused but still declared.

## Test plan
- Valid 3-beat RDMA frame (type 0x0800, proto 17, magic 0x0122, UDP len 158, port 32002), downstream always ready → all 3 beats emerge unchanged, each 1 cycle later; `packets_passed`=1, `packets_dropped`=0.
- Non-RDMA frames: ARP frame (type 0x0806, 2 beats), then IPv4/TCP (proto 6, 4 beats), then a valid frame → only the valid frame emerges; `packets_dropped`=2, `packets_passed`=1.
- Back-pressure: `AXIS_RDMA_TREADY` toggles 1/0 each cycle during a 16-beat valid frame → 16 beats out in order, no duplicates or losses; data is held stable while stalled.
- Boundary lengths: UDP len 30 with 2 beats → dropped; UDP len 31 → passed; single-beat frame (TLAST on header) with valid fields → dropped, `packets_dropped` +1.
- With `RDMA_FILTER_PORT_CHECK_EN`: port 32003 → dropped, port 32002 → passed. Without the macro: both passed.
- Reset asserted for 1 cycle on beat 2 of a passing 5-beat frame → TVALID=0 the next cycle, counters=0, state=HDR; a following valid frame passes normally.

Source files
------------

// File: rtl/rdma_filter.sv
// rdma_filter: passes well-formed RDMA-over-UDP frames from the MAC stream, drops the rest, counts both.
// Latency 1 cycle through one output register, 1 beat/clk. Define RDMA_FILTER_PORT_CHECK_EN to also require the UDP port.
// Backpressure: input ready = output empty or downstream ready; dropped beats are throttled the same way.
`timescale 1ns/1ps
module rdma_filter #(
  parameter int          DATA_WBITS    = 512,
  parameter int          DATA_WBYTS    = DATA_WBITS/8,
  parameter logic [15:0] RDMA_MAGIC    = 16'h0122,
  parameter logic [15:0] RDMA_UDP_PORT = 16'd32002
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WBITS-1:0] AXIS_ETH_TDATA,
  input  logic [DATA_WBYTS-1:0] AXIS_ETH_TKEEP,
  input  logic                  AXIS_ETH_TLAST,
  input  logic                  AXIS_ETH_TVALID,
  output logic                  AXIS_ETH_TREADY,
  output logic [DATA_WBITS-1:0] AXIS_RDMA_TDATA,
  output logic [DATA_WBYTS-1:0] AXIS_RDMA_TKEEP,
  output logic                  AXIS_RDMA_TLAST,
  output logic                  AXIS_RDMA_TVALID,
  input  logic                  AXIS_RDMA_TREADY,
  output logic [63:0]           packets_passed,
  output logic [63:0]           packets_dropped
);

  typedef enum logic [1:0] {HDR, PASS, DROP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        in_hs;
  logic        hdr_ok;
  logic        port_ok;
  logic        fwd;
  logic        pass_inc;
  logic        drop_inc;
  logic [15:0] frame_type;
  logic [7:0]  ip_proto;
  logic [15:0] udp_port;
  logic [15:0] udp_len;
  logic [15:0] rdma_magic;

  // Network byte order: the lower byte offset is the MSB of each field.
  assign frame_type = {AXIS_ETH_TDATA[12*8 +: 8], AXIS_ETH_TDATA[13*8 +: 8]};
  assign ip_proto   =  AXIS_ETH_TDATA[23*8 +: 8];
  assign udp_port   = {AXIS_ETH_TDATA[36*8 +: 8], AXIS_ETH_TDATA[37*8 +: 8]};
  assign udp_len    = {AXIS_ETH_TDATA[38*8 +: 8], AXIS_ETH_TDATA[39*8 +: 8]};
  assign rdma_magic = {AXIS_ETH_TDATA[42*8 +: 8], AXIS_ETH_TDATA[43*8 +: 8]};

`ifdef RDMA_FILTER_PORT_CHECK_EN
  assign port_ok = (udp_port == RDMA_UDP_PORT);
`else
  // Port is ignored; the OR keeps the field and parameter referenced.
  assign port_ok = (udp_port == RDMA_UDP_PORT) | 1'b1;
`endif

  // 31 = 8 UDP header + 22 RDMA header + at least one payload byte.
  assign hdr_ok = (frame_type == 16'h0800) && (ip_proto == 8'd17) &&
                  (rdma_magic == RDMA_MAGIC) && (udp_len >= 16'd31) &&
                  !AXIS_ETH_TLAST && port_ok;

  assign AXIS_ETH_TREADY = !AXIS_RDMA_TVALID | AXIS_RDMA_TREADY;
  assign in_hs           = AXIS_ETH_TVALID & AXIS_ETH_TREADY;

  always_ff @(posedge clk) begin
    if (reset) state <= HDR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR: begin
        if (in_hs && !AXIS_ETH_TLAST) state_nxt = hdr_ok ? PASS : DROP;
      end
      PASS, DROP: begin
        if (in_hs && AXIS_ETH_TLAST) state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  always_comb begin
    fwd      = 1'b0;
    pass_inc = 1'b0;
    drop_inc = 1'b0;
    case (state)
      HDR: begin
        if (in_hs) begin
          fwd      = hdr_ok;
          drop_inc = !hdr_ok && AXIS_ETH_TLAST;
        end
      end
      PASS: begin
        fwd      = in_hs;
        pass_inc = in_hs && AXIS_ETH_TLAST;
      end
      DROP: begin
        drop_inc = in_hs && AXIS_ETH_TLAST;
      end
      default: begin
        fwd = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      AXIS_RDMA_TVALID <= 1'b0;
    end else if (fwd) begin
      AXIS_RDMA_TVALID <= 1'b1;
    end else if (AXIS_RDMA_TREADY) begin
      AXIS_RDMA_TVALID <= 1'b0;
    end
  end

  // Payload register needs no reset; it is qualified by TVALID.
  always_ff @(posedge clk) begin
    if (fwd) begin
      AXIS_RDMA_TDATA <= AXIS_ETH_TDATA;
      AXIS_RDMA_TKEEP <= AXIS_ETH_TKEEP;
      AXIS_RDMA_TLAST <= AXIS_ETH_TLAST;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      packets_passed  <= 64'd0;
      packets_dropped <= 64'd0;
    end else begin
      packets_passed  <= packets_passed  + 64'(pass_inc);
      packets_dropped <= packets_dropped + 64'(drop_inc);
    end
  end

endmodule

// File: tb/tb_rdma_filter.sv
// Bench for rdma_filter: frame-level reference model fed with randomized frames and downstream stalls.
`timescale 1ns/1ps
module tb_rdma_filter;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] eth_tdata = '0;
  logic [63:0]  eth_tkeep = '0;
  logic         eth_tlast = 1'b0;
  logic         eth_tvalid = 1'b0;
  logic         eth_tready;
  logic [511:0] rdma_tdata;
  logic [63:0]  rdma_tkeep;
  logic         rdma_tlast;
  logic         rdma_tvalid;
  logic         rdma_tready = 1'b1;
  logic [63:0]  cnt_passed;
  logic [63:0]  cnt_dropped;

  int          vectors = 0;
  int          miscompares = 0;
  beat_t       cur_fr[$];
  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [63:0] exp_passed = '0;
  logic [63:0] exp_dropped = '0;
  int          rdy_mode = 0;
  bit          gaps = 1'b0;
  int          stall_viol = 0;
  bit          prev_stall = 1'b0;
  beat_t       prev_beat;

  rdma_filter dut (
    .clk              (clk),
    .reset            (reset),
    .AXIS_ETH_TDATA   (eth_tdata),
    .AXIS_ETH_TKEEP   (eth_tkeep),
    .AXIS_ETH_TLAST   (eth_tlast),
    .AXIS_ETH_TVALID  (eth_tvalid),
    .AXIS_ETH_TREADY  (eth_tready),
    .AXIS_RDMA_TDATA  (rdma_tdata),
    .AXIS_RDMA_TKEEP  (rdma_tkeep),
    .AXIS_RDMA_TLAST  (rdma_tlast),
    .AXIS_RDMA_TVALID (rdma_tvalid),
    .AXIS_RDMA_TREADY (rdma_tready),
    .packets_passed   (cnt_passed),
    .packets_dropped  (cnt_dropped)
  );

  always #5 clk = ~clk;

  // Downstream ready: 0 = always ready, 1 = toggle each cycle, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rdy_tready_set(1'b1);
        1:       rdy_tready_set(~rdma_tready);
        default: rdy_tready_set(1'($urandom_range(0, 1)));
      endcase
    end
  end

  task automatic rdy_tready_set(input logic v);
    rdma_tready = v;
  endtask

  // Output monitor: records accepted beats and flags stall-rule breaches.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_stall && rdma_tvalid &&
          (rdma_tdata !== prev_beat.d || rdma_tkeep !== prev_beat.k || rdma_tlast !== prev_beat.l))
        stall_viol++;
      if (rdma_tvalid && !rdma_tready && eth_tready) stall_viol++;
      if (rdma_tvalid && rdma_tready && !reset) begin
        beat_t b;
        b.d = rdma_tdata; b.k = rdma_tkeep; b.l = rdma_tlast;
        got_q.push_back(b);
      end
      prev_stall  = rdma_tvalid && !rdma_tready && !reset;
      prev_beat.d = rdma_tdata; prev_beat.k = rdma_tkeep; prev_beat.l = rdma_tlast;
    end
  end

  function automatic logic [7:0] byte_of(input logic [511:0] d, input int i);
    return d[8*i +: 8];
  endfunction

  // Acceptance rule straight from the header-field definitions.
  function automatic bit model_accept(input beat_t b);
    logic [15:0] ty = {byte_of(b.d, 12), byte_of(b.d, 13)};
    logic [7:0]  pr = byte_of(b.d, 23);
    logic [15:0] ln = {byte_of(b.d, 38), byte_of(b.d, 39)};
    logic [15:0] mg = {byte_of(b.d, 42), byte_of(b.d, 43)};
    bit ok = (ty == 16'h0800) && (pr == 8'd17) && (mg == 16'h0122) && (ln >= 16'd31) && !b.l;
`ifdef RDMA_FILTER_PORT_CHECK_EN
    logic [15:0] pt = {byte_of(b.d, 36), byte_of(b.d, 37)};
    ok = ok && (pt == 16'd32002);
`endif
    return ok;
  endfunction

  task automatic build_frame(input logic [15:0] ty, input logic [7:0] pr, input logic [15:0] pt,
                             input logic [15:0] ln, input logic [15:0] mg, input int n);
    cur_fr.delete();
    for (int i = 0; i < n; i++) begin
      beat_t b;
      for (int w = 0; w < 16; w++) b.d[32*w +: 32] = $urandom;
      b.k = '1;
      b.l = (i == n - 1);
      if (b.l) b.k = {$urandom, $urandom} | 64'h1;
      if (i == 0) begin
        b.d[12*8 +: 8] = ty[15:8]; b.d[13*8 +: 8] = ty[7:0];
        b.d[23*8 +: 8] = pr;
        b.d[36*8 +: 8] = pt[15:8]; b.d[37*8 +: 8] = pt[7:0];
        b.d[38*8 +: 8] = ln[15:8]; b.d[39*8 +: 8] = ln[7:0];
        b.d[42*8 +: 8] = mg[15:8]; b.d[43*8 +: 8] = mg[7:0];
      end
      cur_fr.push_back(b);
    end
  endtask

  task automatic model_frame();
    if (model_accept(cur_fr[0])) begin
      foreach (cur_fr[i]) exp_q.push_back(cur_fr[i]);
      exp_passed++;
    end else begin
      exp_dropped++;
    end
  endtask

  task automatic drive_cur();
    model_frame();
    foreach (cur_fr[i]) begin
      bit acc = 1'b0;
      if (gaps) begin
        eth_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      eth_tvalid = 1'b1;
      eth_tdata  = cur_fr[i].d;
      eth_tkeep  = cur_fr[i].k;
      eth_tlast  = cur_fr[i].l;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        acc = eth_tready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        vectors++; miscompares++;
        $display("FAIL drive_timeout: beat %0d never accepted, tready=%b required 1", i, eth_tready);
      end
    end
    eth_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && got_q.size() < exp_q.size(); t++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic int first_diff();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l)
        return i;
    return -1;
  endfunction

  task automatic start_test(input int mode, input bit g);
    rdy_mode = mode;
    gaps     = g;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++; if (rdma_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b want 0", rdma_tvalid); end
    vectors++; if (eth_tready !== 1'b1) begin miscompares++; $display("FAIL reset_tready: got %b want 1", eth_tready); end
    vectors++; if (cnt_passed !== 64'd0) begin miscompares++; $display("FAIL reset_passed: got %0d want 0", cnt_passed); end
    vectors++; if (cnt_dropped !== 64'd0) begin miscompares++; $display("FAIL reset_dropped: got %0d want 0", cnt_dropped); end
    exp_passed = '0; exp_dropped = '0;
  endtask

  task automatic test_valid_frame();
    start_test(0, 1'b0);
    build_frame(16'h0800, 8'd17, 16'd32002, 16'd158, 16'h0122, 3);
    model_frame();
    foreach (cur_fr[i]) begin
      eth_tvalid = 1'b1; eth_tdata = cur_fr[i].d; eth_tkeep = cur_fr[i].k; eth_tlast = cur_fr[i].l;
      @(posedge clk);
      #1;
      vectors++; if (rdma_tvalid !== 1'b1) begin miscompares++; $display("FAIL valid_lat_vld%0d: got %b want 1", i, rdma_tvalid); end
      vectors++; if (rdma_tdata !== cur_fr[i].d || rdma_tkeep !== cur_fr[i].k) begin
        miscompares++; $display("FAIL valid_lat_dat%0d: got keep %h want keep %h", i, rdma_tkeep, cur_fr[i].k); end
      vectors++; if (rdma_tlast !== cur_fr[i].l) begin miscompares++; $display("FAIL valid_lat_last%0d: got %b want %b", i, rdma_tlast, cur_fr[i].l); end
    end
    eth_tvalid = 1'b0;
    vectors++; if (cnt_passed !== 64'd1) begin miscompares++; $display("FAIL valid_passed_at_last: got %0d want 1", cnt_passed); end
    drain();
    vectors++; if (got_q.size() !== exp_q.size() || first_diff() >= 0) begin
      miscompares++; $display("FAIL valid_stream: got %0d beats (diff at %0d) want %0d", got_q.size(), first_diff(), exp_q.size()); end
    vectors++; if (cnt_dropped !== 64'd0) begin miscompares++; $display("FAIL valid_dropped: got %0d want 0", cnt_dropped); end
  endtask

  task automatic test_non_rdma();
    start_test(0, 1'b0);
    build_frame(16'h0806, 8'd17, 16'd32002, 16'd158, 16'h0122, 2); drive_cur();
    build_frame(16'h0800, 8'd6,  16'd32002, 16'd158, 16'h0122, 4); drive_cur();
    build_frame(16'h0800, 8'd17, 16'd32002, 16'd158, 16'h0122, 3); drive_cur();
    drain();
    vectors++; if (got_q.size() !== exp_q.size() || first_diff() >= 0) begin
      miscompares++; $display("FAIL nonrdma_stream: got %0d beats (diff at %0d) want %0d", got_q.size(), first_diff(), exp_q.size()); end
    vectors++; if (cnt_passed !== exp_passed) begin miscompares++; $display("FAIL nonrdma_passed: got %0d want %0d", cnt_passed, exp_passed); end
    vectors++; if (cnt_dropped !== exp_dropped) begin miscompares++; $display("FAIL nonrdma_dropped: got %0d want %0d", cnt_dropped, exp_dropped); end
  endtask

  task automatic test_back_to_back();
    start_test(1, 1'b0);
    stall_viol = 0;
    build_frame(16'h0800, 8'd17, 16'd32002, 16'd1000, 16'h0122, 16); drive_cur();
    drain();
    vectors++; if (got_q.size() !== exp_q.size() || first_diff() >= 0) begin
      miscompares++; $display("FAIL bp_stream: got %0d beats (diff at %0d) want %0d", got_q.size(), first_diff(), exp_q.size()); end
    vectors++; if (stall_viol !== 0) begin miscompares++; $display("FAIL bp_stall_hold: got %0d violations want 0", stall_viol); end
    vectors++; if (cnt_passed !== exp_passed) begin miscompares++; $display("FAIL bp_passed: got %0d want %0d", cnt_passed, exp_passed); end
    vectors++; if (cnt_dropped !== exp_dropped) begin miscompares++; $display("FAIL bp_dropped: got %0d want %0d", cnt_dropped, exp_dropped); end
  endtask

  task automatic test_boundary();
    start_test(0, 1'b0);
    build_frame(16'h0800, 8'd17, 16'd32002, 16'd30, 16'h0122, 2); drive_cur();
    build_frame(16'h0800, 8'd17, 16'd32002, 16'd31, 16'h0122, 2); drive_cur();
    build_frame(16'h0800, 8'd17, 16'd32002, 16'd158, 16'h0122, 1); drive_cur();
    drain();
    vectors++; if (got_q.size() !== exp_q.size() || first_diff() >= 0) begin
      miscompares++; $display("FAIL bound_stream: got %0d beats (diff at %0d) want %0d", got_q.size(), first_diff(), exp_q.size()); end
    vectors++; if (cnt_passed !== exp_passed) begin miscompares++; $display("FAIL bound_passed: got %0d want %0d", cnt_passed, exp_passed); end
    vectors++; if (cnt_dropped !== exp_dropped) begin miscompares++; $display("FAIL bound_dropped: got %0d want %0d", cnt_dropped, exp_dropped); end
  endtask

  task automatic test_port();
    start_test(0, 1'b0);
    build_frame(16'h0800, 8'd17, 16'd32003, 16'd158, 16'h0122, 3); drive_cur();
    build_frame(16'h0800, 8'd17, 16'd32002, 16'd158, 16'h0122, 3); drive_cur();
    drain();
    vectors++; if (got_q.size() !== exp_q.size() || first_diff() >= 0) begin
      miscompares++; $display("FAIL port_stream: got %0d beats (diff at %0d) want %0d", got_q.size(), first_diff(), exp_q.size()); end
    vectors++; if (cnt_passed !== exp_passed) begin miscompares++; $display("FAIL port_passed: got %0d want %0d", cnt_passed, exp_passed); end
    vectors++; if (cnt_dropped !== exp_dropped) begin miscompares++; $display("FAIL port_dropped: got %0d want %0d", cnt_dropped, exp_dropped); end
  endtask

  task automatic test_reset_midframe();
    start_test(0, 1'b0);
    build_frame(16'h0800, 8'd17, 16'd32002, 16'd500, 16'h0122, 5);
    for (int i = 0; i < 2; i++) begin
      eth_tvalid = 1'b1; eth_tdata = cur_fr[i].d; eth_tkeep = cur_fr[i].k; eth_tlast = cur_fr[i].l;
      @(posedge clk);
      #1;
    end
    eth_tdata = cur_fr[2].d; eth_tkeep = cur_fr[2].k; eth_tlast = cur_fr[2].l;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    eth_tvalid = 1'b0;
    vectors++; if (rdma_tvalid !== 1'b0) begin miscompares++; $display("FAIL midrst_tvalid: got %b want 0", rdma_tvalid); end
    vectors++; if (cnt_passed !== 64'd0 || cnt_dropped !== 64'd0) begin
      miscompares++; $display("FAIL midrst_counters: got %0d/%0d want 0/0", cnt_passed, cnt_dropped); end
    vectors++; if (eth_tready !== 1'b1) begin miscompares++; $display("FAIL midrst_tready: got %b want 1", eth_tready); end
    exp_q.delete(); got_q.delete();
    exp_passed = '0; exp_dropped = '0;
    // A non-RDMA frame first: it would leak out if the FSM were still in PASS.
    build_frame(16'h0806, 8'd17, 16'd32002, 16'd158, 16'h0122, 2); drive_cur();
    build_frame(16'h0800, 8'd17, 16'd32002, 16'd158, 16'h0122, 3); drive_cur();
    drain();
    vectors++; if (got_q.size() !== exp_q.size() || first_diff() >= 0) begin
      miscompares++; $display("FAIL midrst_stream: got %0d beats (diff at %0d) want %0d", got_q.size(), first_diff(), exp_q.size()); end
    vectors++; if (cnt_passed !== exp_passed) begin miscompares++; $display("FAIL midrst_passed: got %0d want %0d", cnt_passed, exp_passed); end
    vectors++; if (cnt_dropped !== exp_dropped) begin miscompares++; $display("FAIL midrst_dropped: got %0d want %0d", cnt_dropped, exp_dropped); end
  endtask

  task automatic test_random();
    start_test(2, 1'b1);
    stall_viol = 0;
    for (int f = 0; f < 40; f++) begin
      int          sel = $urandom_range(0, 6);
      logic [15:0] ty  = (sel == 1) ? 16'(16'h86DD) : 16'h0800;
      logic [7:0]  pr  = (sel == 2) ? 8'd6 : 8'd17;
      logic [15:0] mg  = (sel == 3) ? 16'h0123 : 16'h0122;
      logic [15:0] ln  = (sel == 4) ? 16'($urandom_range(0, 30)) : 16'($urandom_range(31, 1500));
      logic [15:0] pt  = ($urandom_range(0, 3) == 0) ? 16'd32003 : 16'd32002;
      int          n   = (sel == 5) ? 1 : $urandom_range(2, 6);
      build_frame(ty, pr, pt, ln, mg, n);
      drive_cur();
    end
    drain();
    vectors++; if (got_q.size() !== exp_q.size() || first_diff() >= 0) begin
      miscompares++; $display("FAIL rand_stream: got %0d beats (diff at %0d) want %0d", got_q.size(), first_diff(), exp_q.size()); end
    vectors++; if (stall_viol !== 0) begin miscompares++; $display("FAIL rand_stall_hold: got %0d violations want 0", stall_viol); end
    vectors++; if (cnt_passed !== exp_passed) begin miscompares++; $display("FAIL rand_passed: got %0d want %0d", cnt_passed, exp_passed); end
    vectors++; if (cnt_dropped !== exp_dropped) begin miscompares++; $display("FAIL rand_dropped: got %0d want %0d", cnt_dropped, exp_dropped); end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_non_rdma();
    test_back_to_back();
    test_boundary();
    test_port();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
